// File: rtl/wave_meter_pkg.sv
// Shared types and default sizing for the wave_meter receive path.
package wave_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int CLK_PER_US_DEF = 12;
  localparam int W_DEF          = 8;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restartable via clr.
module us_tick_gen
  import wave_meter_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_PER_US > 2) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wave_meter.sv
// Measures high/low widths of a square wave in whole microseconds, one report per period.
// Optional idle timeout (stuck flag) is built when WAVE_METER_TIMEOUT_EN is defined.
module wave_meter
  import wave_meter_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int W          = W_DEF,
  parameter int TIMEOUT_US = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wave_in,
  output logic [W-1:0] on_us,
  output logic [W-1:0] off_us,
  output logic         valid,
  output logic         sat,
  output logic         stuck
);

  if (CLK_PER_US < 2 || TIMEOUT_US < 1) begin : g_param_check
    $error("wave_meter: CLK_PER_US must be >= 2 and TIMEOUT_US >= 1");
  end

  logic         rst_meta_q, rst_n_q;
  logic         sync1_q, sync2_q, prev_q;
  logic [1:0]   prime_q;
  logic         primed, edge_any, rise, fall, pre_edge, tick;
  state_e       state_q, state_d;
  logic [W-1:0] dur_q, dur_d, on_hold_q, on_hold_d;
  logic [W-1:0] on_q, on_d, off_q, off_d;
  logic         sat_pend_q, sat_pend_d, sat_q, sat_d, valid_q, valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  // Edges are masked until the synchroniser holds real pin samples, so a pin
  // that is already high when reset releases does not fake a rising edge.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      sync1_q <= wave_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!primed) prime_q <= prime_q + 2'd1;
    end
  end

  assign primed   = (prime_q == 2'd3);
  assign edge_any = primed && (sync2_q != prev_q);
  assign rise     = edge_any && sync2_q;
  assign fall     = edge_any && !sync2_q;
  // Clearing the prescaler one cycle ahead puts count 0 on the edge cycle,
  // so an exact n-us width collects exactly n ticks before the next edge.
  assign pre_edge = sync1_q ^ sync2_q;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk   (clk),
    .reset (rst_n_q),
    .clr   (pre_edge),
    .tick  (tick)
  );

`ifdef WAVE_METER_TIMEOUT_EN
  localparam int IW = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US + 1) : 1;
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT_US - 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          stuck_q, stuck_d;
`endif

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    on_hold_d  = on_hold_q;
    sat_pend_d = sat_pend_q;
    on_d       = on_q;
    off_d      = off_q;
    sat_d      = sat_q;
    valid_d    = 1'b0;
`ifdef WAVE_METER_TIMEOUT_EN
    idle_d     = idle_q;
    stuck_d    = stuck_q;
`endif

    if (edge_any) begin
      dur_d = '0;
    end else if (tick) begin
      if (dur_q == '1) sat_pend_d = 1'b1;
      else             dur_d      = dur_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          sat_pend_d = 1'b0;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          on_hold_d = dur_q;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          on_d       = on_hold_q;
          off_d      = dur_q;
          sat_d      = sat_pend_q;
          valid_d    = 1'b1;
          sat_pend_d = 1'b0;
          state_d    = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef WAVE_METER_TIMEOUT_EN
    if (edge_any) begin
      idle_d  = '0;
      stuck_d = 1'b0;
    end else if (tick && !stuck_q) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == TO_LAST) begin
        stuck_d = 1'b1;
        state_d = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q    <= IDLE;
      dur_q      <= '0;
      on_hold_q  <= '0;
      sat_pend_q <= 1'b0;
      on_q       <= '0;
      off_q      <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
`ifdef WAVE_METER_TIMEOUT_EN
      idle_q     <= '0;
      stuck_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      on_hold_q  <= on_hold_d;
      sat_pend_q <= sat_pend_d;
      on_q       <= on_d;
      off_q      <= off_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
`ifdef WAVE_METER_TIMEOUT_EN
      idle_q     <= idle_d;
      stuck_q    <= stuck_d;
`endif
    end
  end

  assign on_us  = on_q;
  assign off_us = off_q;
  assign valid  = valid_q;
  assign sat    = sat_q;
`ifdef WAVE_METER_TIMEOUT_EN
  assign stuck  = stuck_q;
`else
  assign stuck  = 1'b0;
`endif

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter (CLK_PER_US=12, W=8); timeout case runs with WAVE_METER_TIMEOUT_EN.
module tb_wave_meter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wave_in = 1'b0;
  logic [7:0] on_us, off_us;
  logic       valid, sat, stuck;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int consec = 0;
  logic vld_prev = 1'b0;

  typedef struct {
    int on_v;
    int off_v;
    int sat_v;
    int cyc_v;
  } rec_t;
  rec_t vq[$];

  wave_meter #(.CLK_PER_US(12), .W(8), .TIMEOUT_US(20)) dut (
    .clk     (clk),
    .reset   (reset),
    .wave_in (wave_in),
    .on_us   (on_us),
    .off_us  (off_us),
    .valid   (valid),
    .sat     (sat),
    .stuck   (stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      rec_t r;
      r.on_v  = int'(on_us);
      r.off_v = int'(off_us);
      r.sat_v = int'(sat);
      r.cyc_v = cyc;
      vq.push_back(r);
    end
    if (valid && vld_prev) consec++;
    vld_prev = valid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pin change is aligned 1 ns after a rising edge; holds for n clocks.
  task automatic set_wave(input logic v, input int n);
    wave_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    vq.delete();
    consec = 0;
  endtask

  task automatic chk_reports(input string tag, input int n, input int on_e, input int off_e,
                             input int sat_e, input int gap);
    chk({tag, "_count"}, vq.size(), n);
    for (int i = 0; i < vq.size(); i++) begin
      chk({tag, "_on"}, vq[i].on_v, on_e);
      chk({tag, "_off"}, vq[i].off_v, off_e);
      chk({tag, "_sat"}, vq[i].sat_v, sat_e);
      if (i > 0) chk({tag, "_gap"}, vq[i].cyc_v - vq[i-1].cyc_v, gap);
    end
    chk({tag, "_consec"}, consec, 0);
  endtask

  initial begin
    // 1: reset held low while the wave toggles
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_wave(1'(i % 2 == 0), 20);
    @(negedge clk);
    chk("t1_rst_on", int'(on_us), 0);
    chk("t1_rst_off", int'(off_us), 0);
    chk("t1_rst_sat", int'(sat), 0);
    chk("t1_rst_valid", int'(valid), 0);
    chk("t1_rst_stuck", int'(stuck), 0);
    chk("t1_rst_count", vq.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_wave(1'b0, 10);
    set_wave(1'b1, 36);
    set_wave(1'b0, 60);
    chk("t1_post_count", vq.size(), 0);
    chk("t1_post_on", int'(on_us), 0);

    // 2: 3 us high / 5 us low
    do_reset();
    set_wave(1'b0, 30);
    for (int i = 0; i < 4; i++) begin
      set_wave(1'b1, 36);
      set_wave(1'b0, 60);
    end
    set_wave(1'b1, 40);
    chk_reports("t2", 4, 3, 5, 0, 96);
    chk("t2_stuck", int'(stuck), 0);

    // 4: reset pulsed mid-HIGH, outputs were 3/5 before it
    vq.delete();
    wave_in = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_rst_on", int'(on_us), 0);
    chk("t4_rst_off", int'(off_us), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    set_wave(1'b1, 20);
    set_wave(1'b0, 60);
    set_wave(1'b1, 36);
    set_wave(1'b0, 60);
    set_wave(1'b1, 40);
    chk_reports("t4", 1, 3, 5, 0, 0);

`ifndef WAVE_METER_TIMEOUT_EN
    // 3: 300 us high saturates, next period clean
    do_reset();
    set_wave(1'b0, 30);
    set_wave(1'b1, 3600);
    set_wave(1'b0, 24);
    set_wave(1'b1, 36);
    chk("t3_count1", vq.size(), 1);
    chk("t3_sat_on", int'(on_us), 255);
    chk("t3_sat_off", int'(off_us), 2);
    chk("t3_sat_flag", int'(sat), 1);
    set_wave(1'b0, 60);
    set_wave(1'b1, 40);
    chk("t3_count2", vq.size(), 2);
    chk("t3_next_on", int'(on_us), 3);
    chk("t3_next_off", int'(off_us), 5);
    chk("t3_next_sat", int'(sat), 0);
    chk("t3_stuck", int'(stuck), 0);
`endif

    // 5: 2.5 us high / ~0.4 us low truncates
    do_reset();
    set_wave(1'b0, 30);
    for (int i = 0; i < 3; i++) begin
      set_wave(1'b1, 30);
      set_wave(1'b0, 5);
    end
    set_wave(1'b1, 40);
    chk_reports("t5", 3, 2, 0, 0, 35);

`ifdef WAVE_METER_TIMEOUT_EN
    // 6: wave stops high, timeout after 20 us, then resumes
    do_reset();
    set_wave(1'b0, 30);
    set_wave(1'b1, 36);
    set_wave(1'b0, 60);
    set_wave(1'b1, 200);
    chk("t6_stuck_early", int'(stuck), 0);
    set_wave(1'b1, 60);
    chk("t6_stuck", int'(stuck), 1);
    chk("t6_hold_on", int'(on_us), 3);
    chk("t6_hold_off", int'(off_us), 5);
    chk("t6_count1", vq.size(), 1);
    set_wave(1'b0, 10);
    chk("t6_unstuck", int'(stuck), 0);
    set_wave(1'b0, 50);
    set_wave(1'b1, 36);
    set_wave(1'b0, 60);
    chk("t6_dropped", vq.size(), 1);
    set_wave(1'b1, 40);
    chk("t6_count2", vq.size(), 2);
    chk("t6_on", int'(on_us), 3);
    chk("t6_off", int'(off_us), 5);
    chk("t6_sat", int'(sat), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
